// File: rtl/bin_to_dec_pkg.sv
// Shared widths and the one-hot decode function for the 2-to-4 decoder.
package bin_to_dec_pkg;

  localparam int SEL_W   = 2;
  localparam int NUM_OUT = 4;

  function automatic logic [NUM_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_OUT-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bin_to_dec_decoder.sv
// Registered 2-to-4 one-hot decoder of {in1,in0}; 1-cycle latency, optional inverted outputs.
// No backpressure: a new code is accepted on every rising edge.
module bin_to_dec_decoder
  import bin_to_dec_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in0,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3
);

  localparam logic [NUM_OUT-1:0] IDLE_LVL = {NUM_OUT{ACTIVE_LOW}};

  logic [NUM_OUT-1:0] dec_d;
  logic [NUM_OUT-1:0] dec_q;

  // Polarity is folded in before the flop so the outputs are clean register outputs.
  always_comb begin
    dec_d = onehot4({in1, in0});
    if (ACTIVE_LOW) begin
      dec_d = ~dec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= IDLE_LVL;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign o0 = dec_q[0];
  assign o1 = dec_q[1];
  assign o2 = dec_q[2];
  assign o3 = dec_q[3];

endmodule

// File: tb/tb_bin_to_dec_decoder.sv
// Directed and random checks of both polarities of bin_to_dec_decoder against a select-to-vector model.
module tb_bin_to_dec_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in1 = 1'b1;
  logic in0 = 1'b1;

  logic h0, h1, h2, h3;
  logic l0, l1, l2, l3;
  logic [3:0] obs_h;
  logic [3:0] obs_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign obs_h = {h3, h2, h1, h0};
  assign obs_l = {l3, l2, l1, l0};

  bin_to_dec_decoder #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .in1(in1), .in0(in0),
    .o0(h0), .o1(h1), .o2(h2), .o3(h3)
  );

  bin_to_dec_decoder #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in1(in1), .in0(in0),
    .o0(l0), .o1(l1), .o2(l2), .o3(l3)
  );

  // Reference: selected output index = 2*in1 + in0; reset drives every output idle.
  function automatic logic [3:0] model(input bit al, input bit r, input int code);
    logic [3:0] v;
    if (r) return al ? 4'b1111 : 4'b0000;
    v = 4'(1 << code);
    return al ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input bit r, input int code);
    check({tag, "_hi"}, obs_h, model(1'b0, r, code));
    check({tag, "_lo"}, obs_l, model(1'b1, r, code));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int code);
    in1 = code[1];
    in0 = code[0];
  endtask

  initial begin
    int code;
    int prev;

    // Reset held two cycles with code 11 on the inputs.
    rst = 1'b1;
    set_code(3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_both("reset", 1'b1, 3);
    end

    // Sweep: each code held for 100 ns; outputs must be stable throughout.
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_code(c);
      for (int k = 0; k < 10; k++) begin
        tick();
        check_both($sformatf("sweep%0d", c), 1'b0, c);
      end
    end

    // Latency: a change just after an edge is invisible until the next edge.
    set_code(0);
    tick();
    check_both("lat_pre", 1'b0, 0);
    set_code(3);
    @(negedge clk);
    check_both("lat_hold", 1'b0, 0);
    tick();
    check_both("lat_post", 1'b0, 3);

    // Inputs sampled only at the edge: a pulse between edges is ignored.
    set_code(1);
    @(negedge clk);
    #1;
    set_code(3);
    tick();
    check_both("glitch", 1'b0, 3);

    // Mid-operation reset with code 10 held.
    set_code(2);
    tick();
    check_both("mid_dec", 1'b0, 2);
    rst = 1'b1;
    tick();
    check_both("mid_rst", 1'b1, 2);
    rst = 1'b0;
    tick();
    check_both("mid_rel", 1'b0, 2);

    // Explicit code 01 on both polarities.
    set_code(1);
    tick();
    check("code01_hi", obs_h, 4'b0010);
    check("code01_lo", obs_l, 4'b1101);

    // Random codes, one per cycle, with a one-hot invariant check.
    for (int n = 0; n < 1000; n++) begin
      prev = $urandom_range(0, 3);
      set_code(prev);
      tick();
      check_both("rand", 1'b0, prev);
      code = $countones(obs_h);
      total++;
      assert (code == 1)
      else begin
        bad++;
        $error("FAIL onehot_hi observed=%0d expected=1", code);
      end
      code = $countones(~obs_l);
      total++;
      assert (code == 1)
      else begin
        bad++;
        $error("FAIL onehot_lo observed=%0d expected=1", code);
      end
    end

    // Final reset on the inverted instance idles at all-ones.
    rst = 1'b1;
    tick();
    check("final_rst_lo", obs_l, 4'b1111);
    check("final_rst_hi", obs_h, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
